// File: rtl/fb_line_arbiter_if.sv
// Draw-request, framebuffer and linebuffer signals of the line arbiter.
// master: the arbiter side. slave: the surrounding system (drawer, memory, linebuffer).
`timescale 1ns/1ps
interface fb_line_arbiter_if #(
  parameter int unsigned ADDRW = 19,
  parameter int unsigned DATAW = 8,
  parameter int unsigned LBAW  = 10
);
  logic             drw_valid;
  logic             drw_ready;
  logic [ADDRW-1:0] drw_addr;
  logic [DATAW-1:0] drw_data;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_we;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;
  logic             lb_we;
  logic [LBAW-1:0]  lb_addr;
  logic [DATAW-1:0] lb_data;

  modport master (
    input  drw_valid, drw_addr, drw_data, mem_rdata,
    output drw_ready, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_data
  );

  modport slave (
    output drw_valid, drw_addr, drw_data, mem_rdata,
    input  drw_ready, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/fb_line_arbiter.sv
// Framebuffer port arbiter: copies the next display line into the linebuffer
// with absolute priority, and lets drawing writes through only while idle.
`timescale 1ns/1ps
module fb_line_arbiter #(
  parameter int unsigned CORDW = 16,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned ADDRW = 19,
  parameter int unsigned DATAW = 8,
  parameter int unsigned LBAW  = 10
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    line,
  input  logic                    frame,
  input  logic signed [CORDW-1:0] sy,
  output logic                    fetch_busy,
  output logic                    overrun,
  fb_line_arbiter_if.master       bus
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] ROW_MAX = CORDW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    fetch_x_q, fetch_x_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic             lb_we_q, lb_we_d;
  logic [LBAW-1:0]  lb_addr_q, lb_addr_d;
  logic             overrun_q, overrun_d;

  logic signed [CORDW-1:0] row_c;
  logic                    row_ok_c;
  logic                    fetch_start_c;
  logic                    drw_ready_c;
  logic                    mem_we_c;
  logic [ADDRW-1:0]        mem_addr_c;
  logic [DATAW-1:0]        mem_wdata_c;

  // Target row is the line after the current one; sy=-1 prefetches row 0.
  always_comb begin
    row_c         = sy + CORDW'(1);
    row_ok_c      = !row_c[CORDW-1] && (row_c <= ROW_MAX);
    fetch_start_c = (state_q == IDLE) && line && row_ok_c;
  end

  // Next-state, fetch sequencing, memory port mux and overrun tracking.
  always_comb begin
    state_d     = state_q;
    fetch_x_d   = fetch_x_q;
    base_d      = base_q;
    lb_we_d     = 1'b0;
    lb_addr_d   = lb_addr_q;
    overrun_d   = overrun_q;
    drw_ready_c = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (fetch_start_c) begin
          state_d   = FETCH;
          fetch_x_d = '0;
          base_d    = ADDRW'(row_c) * ADDRW'(H_RES);
        end else begin
          // Draw port only opens once reset has been released.
          drw_ready_c = rst_pix_n;
          if (bus.drw_valid && rst_pix_n) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = bus.drw_addr;
            mem_wdata_c = bus.drw_data;
          end
        end
      end
      FETCH: begin
        mem_addr_c = base_q + ADDRW'(fetch_x_q);
        lb_we_d    = 1'b1;
        lb_addr_d  = LBAW'(fetch_x_q);
        if (fetch_x_q == X_LAST) begin
          state_d = DRAIN;
        end else begin
          fetch_x_d = fetch_x_q + XW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A line strobe while busy sets the flag even if frame clears it in the same cycle.
    if (frame) begin
      overrun_d = 1'b0;
    end
    if (line && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state_q   <= IDLE;
      fetch_x_q <= '0;
      base_q    <= '0;
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_x_q <= fetch_x_d;
      base_q    <= base_d;
      lb_we_q   <= lb_we_d;
      lb_addr_q <= lb_addr_d;
      overrun_q <= overrun_d;
    end
  end

  // Read data arrives one cycle after its address, aligned with the registered lb_we.
  always_comb begin
    bus.lb_data = lb_we_q ? bus.mem_rdata : '0;
  end

  assign bus.lb_we     = lb_we_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.drw_ready = drw_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign fetch_busy    = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fb_line_arbiter.sv
// Directed bench for fb_line_arbiter: idle vector table plus fetch, overrun and reset sequences.
`timescale 1ns/1ps
module tb_fb_line_arbiter;

  localparam int CORDW = 16;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int ADDRW = 19;
  localparam int DATAW = 8;
  localparam int LBAW  = 10;

  logic                    clk = 1'b0;
  logic                    rst_pix_n;
  logic                    line;
  logic                    frame;
  logic signed [CORDW-1:0] sy;
  logic                    fetch_busy;
  logic                    overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  fb_line_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW), .LBAW(LBAW)) bus ();

  fb_line_arbiter #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
    .ADDRW(ADDRW), .DATAW(DATAW), .LBAW(LBAW)
  ) dut (
    .clk_pix    (clk),
    .rst_pix_n  (rst_pix_n),
    .line       (line),
    .frame      (frame),
    .sy         (sy),
    .fetch_busy (fetch_busy),
    .overrun    (overrun),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer model: content is address & 0xFF, read latency one cycle.
  always @(posedge clk) bus.mem_rdata <= DATAW'(bus.mem_addr[7:0]);

  // Count accepted memory writes.
  always @(posedge clk) if (rst_pix_n && bus.mem_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic line;
    logic frame;
    int   sy;
    logic dv;
    int   da;
    int   dd;
    logic e_rdy;
    logic e_we;
    int   e_addr;
    int   e_wd;
  } vec_t;

  // Runs one complete line fetch and checks its whole timeline.
  task automatic run_fetch(input int sy_v, input int ovr_at, input logic ovr_frame,
                           input logic drw_held);
    int base, busy_n, bad_addr, lb_n, lb_bad, rdy0, last_addr;
    logic end_busy, end_rdy, end_we;
    logic [ADDRW-1:0] end_addr;
    base = (sy_v + 1) * H_RES;
    busy_n = 0; bad_addr = 0; lb_n = 0; lb_bad = 0; rdy0 = 0; last_addr = -1;
    end_busy = 1'b1; end_rdy = 1'b0; end_we = 1'b0; end_addr = '0;
    @(negedge clk);
    line = 1'b1;
    sy = CORDW'(sy_v);
    #2;
    chk("start_busy", fetch_busy, 0);
    chk("start_we", bus.mem_we, 0);
    if (!bus.drw_ready) rdy0++;
    for (int k = 1; k <= 642; k++) begin
      @(negedge clk);
      line = 1'b0;
      frame = 1'b0;
      if (k == ovr_at) begin
        line = 1'b1;
        sy = CORDW'(5);
        frame = ovr_frame;
      end
      #2;
      if (fetch_busy) busy_n++;
      if (!bus.drw_ready) rdy0++;
      if (k <= 640) begin
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== ADDRW'(base + k - 1)) bad_addr++;
        if (k == 640) last_addr = int'(bus.mem_addr);
      end else if (k == 641) begin
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0) bad_addr++;
      end else begin
        end_busy = fetch_busy;
        end_rdy  = bus.drw_ready;
        end_we   = bus.mem_we;
        end_addr = bus.mem_addr;
      end
      if (bus.lb_we) begin
        if (bus.lb_addr !== LBAW'(lb_n) || bus.lb_data !== DATAW'((base + lb_n) & 255)) lb_bad++;
        lb_n++;
      end
    end
    line = 1'b0;
    frame = 1'b0;
    chk("fetch_busy_cycles", busy_n, 641);
    chk("fetch_addr_errors", bad_addr, 0);
    chk("fetch_last_addr", last_addr, base + H_RES - 1);
    chk("lb_pulses", lb_n, H_RES);
    chk("lb_entry_errors", lb_bad, 0);
    chk("ready_low_cycles", rdy0, 642);
    chk("end_busy", end_busy, 0);
    chk("end_ready", end_rdy, 1);
    if (drw_held) begin
      chk("held_draw_we", end_we, 1);
      chk("held_draw_addr", end_addr, 1234);
      chk("held_draw_data", bus.mem_wdata, 8'h5A);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int good, we0;

    tbl[0] = '{1'b0, 1'b0,    0, 1'b0,      0,    0, 1'b1, 1'b0,      0,    0};
    tbl[1] = '{1'b0, 1'b0,    0, 1'b1,   1234, 8'h5A, 1'b1, 1'b1,   1234, 8'h5A};
    tbl[2] = '{1'b1, 1'b0,  479, 1'b1,   2000, 8'h11, 1'b1, 1'b1,   2000, 8'h11};
    tbl[3] = '{1'b1, 1'b0,   -5, 1'b0,      0,    0, 1'b1, 1'b0,      0,    0};
    tbl[4] = '{1'b1, 1'b0,   -2, 1'b1, 307199, 8'hFF, 1'b1, 1'b1, 307199, 8'hFF};
    tbl[5] = '{1'b1, 1'b1, 1000, 1'b0,      0,    0, 1'b1, 1'b0,      0,    0};

    // Reset with a draw request pending.
    rst_pix_n = 1'b0; line = 1'b0; frame = 1'b0; sy = '0;
    bus.drw_valid = 1'b1; bus.drw_addr = ADDRW'(77); bus.drw_data = 8'h33;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.drw_ready, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_lb_we", bus.lb_we, 0);
    chk("rst_lb_addr", bus.lb_addr, 0);
    chk("rst_lb_data", bus.lb_data, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_overrun", overrun, 0);
    rst_pix_n = 1'b1;
    #2;
    chk("rel_ready", bus.drw_ready, 1);
    chk("rel_we", bus.mem_we, 1);
    chk("rel_addr", bus.mem_addr, 77);
    @(negedge clk);
    bus.drw_valid = 1'b0;

    // Idle vectors: draws, ignored line strobes, frame strobe.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      line = tbl[i].line;
      frame = tbl[i].frame;
      sy = CORDW'(tbl[i].sy);
      bus.drw_valid = tbl[i].dv;
      bus.drw_addr = ADDRW'(tbl[i].da);
      bus.drw_data = DATAW'(tbl[i].dd);
      #2;
      chk($sformatf("vec%0d_ready", i), bus.drw_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_we", i), bus.mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, tbl[i].e_wd);
      @(negedge clk);
      line = 1'b0; frame = 1'b0; bus.drw_valid = 1'b0;
      #2;
      chk($sformatf("vec%0d_busy_after", i), fetch_busy, 0);
      chk($sformatf("vec%0d_overrun", i), overrun, 0);
    end

    // Row 0 fetch.
    run_fetch(-1, 0, 1'b0, 1'b0);
    chk("row0_overrun", overrun, 0);

    // Last row with a draw stalled behind it.
    @(negedge clk);
    bus.drw_valid = 1'b1; bus.drw_addr = ADDRW'(1234); bus.drw_data = 8'h5A;
    run_fetch(478, 0, 1'b0, 1'b1);
    @(negedge clk);
    bus.drw_valid = 1'b0;

    // Second line mid-fetch sets overrun; frame clears it.
    run_fetch(10, 300, 1'b0, 1'b0);
    chk("overrun_set", overrun, 1);
    @(negedge clk); frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    #2;
    chk("overrun_cleared", overrun, 0);

    // Line and frame together while busy: set wins.
    run_fetch(20, 100, 1'b1, 1'b0);
    chk("overrun_coincident", overrun, 1);
    @(negedge clk); frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    #2;
    chk("overrun_cleared2", overrun, 0);

    // Reset at fetch_x=100.
    @(negedge clk); line = 1'b1; sy = CORDW'(10);
    @(negedge clk); line = 1'b0;
    repeat (100) @(negedge clk);
    #2;
    chk("midfetch_addr", bus.mem_addr, 11 * 640 + 100);
    rst_pix_n = 1'b0;
    bus.drw_valid = 1'b1; bus.drw_addr = ADDRW'(500); bus.drw_data = 8'h09;
    @(negedge clk);
    #2;
    chk("abort_busy", fetch_busy, 0);
    chk("abort_lb_we", bus.lb_we, 0);
    chk("abort_ready", bus.drw_ready, 0);
    chk("abort_mem_we", bus.mem_we, 0);
    rst_pix_n = 1'b1;
    #1;
    chk("abort_rel_ready", bus.drw_ready, 1);
    chk("abort_rel_we", bus.mem_we, 1);
    chk("abort_rel_addr", bus.mem_addr, 500);
    @(negedge clk);
    bus.drw_valid = 1'b0;

    // Five back-to-back draws.
    @(negedge clk);
    good = 0;
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.drw_valid = 1'b1;
      bus.drw_addr = ADDRW'(100 + i);
      bus.drw_data = DATAW'(i * 3 + 1);
      #2;
      if (bus.drw_ready === 1'b1 && bus.mem_we === 1'b1 &&
          bus.mem_addr === ADDRW'(100 + i) && bus.mem_wdata === DATAW'(i * 3 + 1)) good++;
      @(negedge clk);
    end
    bus.drw_valid = 1'b0;
    #2;
    chk("b2b_matching", good, 5);
    chk("b2b_we_pulses", we_cnt - we0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_line_arbiter.md
FB_LINE_ARBITER -- requirements
Module: fb_line_arbiter

Interface
REQ-001 Parameters SHALL be: CORDW, default 16, signed screen coordinate width; H_RES, default 640, active pixels per line; V_RES, default 480, active lines; ADDRW, default 19, framebuffer address width; DATAW, default 8, pixel data width; LBAW, default 10, linebuffer address width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk_pix  in  1  pixel clock; all logic on rising edge.
REQ-004 rst_pix_n  in  1  synchronous active-low reset.
REQ-005 line  in  1  one-cycle start-of-line strobe from display timing.
REQ-006 frame  in  1  one-cycle start-of-frame strobe.
REQ-007 sy  in  CORDW signed  current display line, negative in vertical blanking.
REQ-008 drw_valid / drw_ready  in / out  1  drawing write request / accept.
REQ-009 drw_addr / drw_data  in  ADDRW / DATAW  drawing write address / pixel.
REQ-010 mem_addr / mem_we / mem_wdata  out  ADDRW / 1 / DATAW  single-port framebuffer port.
REQ-011 mem_rdata  in  DATAW  framebuffer read data, valid exactly 1 cycle after mem_addr.
REQ-012 lb_we / lb_addr / lb_data  out  1 / LBAW / DATAW  linebuffer write port.
REQ-013 fetch_busy  out  1  high while the line fetch owns memory.
REQ-014 overrun  out  1  sticky error: line strobe arrived during a fetch.

Function
REQ-015 FSM states SHALL be IDLE, FETCH and DRAIN.
REQ-016 A fetch start SHALL be line=1 in IDLE with -1 <= sy <= V_RES-2; the target row is sy+1.
REQ-017 On fetch start, the FSM SHALL enter FETCH next cycle with fetch_x=0 and base=(sy+1)*H_RES, computed at ADDRW width.
REQ-018 In FETCH, the outputs SHALL be mem_addr=base+fetch_x and mem_we=0; fetch_x SHALL increment each cycle.
REQ-019 At fetch_x=H_RES-1, FETCH SHALL go to DRAIN; DRAIN SHALL last 1 cycle, then return to IDLE.
REQ-020 lb_we SHALL be registered and high exactly 1 cycle after each FETCH cycle, with lb_addr=that cycle's fetch_x and lb_data=mem_rdata.
REQ-021 Each fetch SHALL write exactly H_RES linebuffer entries, addresses 0..H_RES-1 in order.
REQ-022 fetch_busy SHALL be 1 in FETCH and DRAIN and 0 in IDLE.
REQ-023 drw_ready SHALL be 1 only in IDLE with no fetch start that cycle, and 0 during reset.
REQ-024 On drw_valid and drw_ready, the same cycle SHALL drive mem_we=1, mem_addr=drw_addr and mem_wdata=drw_data; a transfer occurs only then.
REQ-025 The display fetch SHALL have absolute priority.
  - line and drw_valid together in IDLE: the fetch starts and the draw request stalls.
  - A stalled draw request SHALL hold drw_addr and drw_data stable.
REQ-026 line outside -1..V_RES-2 SHALL be ignored: stay IDLE, drw_ready unaffected.
REQ-027 line in FETCH or DRAIN SHALL be ignored for fetching and SHALL set overrun=1.
REQ-028 overrun SHALL clear on frame=1; if line and frame coincide in FETCH or DRAIN, overrun SHALL become 1.
REQ-029 When neither FETCH nor a draw transfer, the outputs SHALL be mem_we=0 and mem_addr=0.
REQ-030 No fetch row SHALL exceed V_RES-1 and no address SHALL exceed H_RES*V_RES-1.

Reset
REQ-031 While rst_pix_n=0 at a clock edge, the block SHALL reset to:
  - state=IDLE, fetch_x=0, base=0;
  - lb_we=0, lb_addr=0, lb_data=0;
  - overrun=0, fetch_busy=0, drw_ready=0, mem_we=0, mem_addr=0.
REQ-032 Reset asserted mid-fetch SHALL abort the fetch; no lb_we pulse SHALL occur in the cycle after reset.
REQ-033 After rst_pix_n returns to 1, the block SHALL accept draw requests the next cycle.

Verification
REQ-034 line with sy=-1 (model memory = address & 0xFF): FETCH for 640 cycles, then DRAIN; lb_we pulses 640 times; lb_addr 0..639; lb_data=addr&0xFF, base=0.
REQ-035 line with sy=478: base=479*640=306560, last mem_addr=307199; line with sy=479 or sy=-5: no fetch, fetch_busy stays 0.
REQ-036 drw_valid held with drw_addr=1234, drw_data=0x5A, line at the same cycle: drw_ready=0 for 642 cycles (640 FETCH + DRAIN + start); then one-cycle write at mem_addr=1234, wdata=0x5A.
REQ-037 Second line strobe 300 cycles into a fetch: overrun=1, fetch completes unaffected; next frame strobe clears overrun to 0.
REQ-038 rst_pix_n=0 at fetch_x=100: next cycle, state IDLE, lb_we=0, fetch_busy=0, drw_ready=0; after release, drw_ready=1 with drw_valid=1.
REQ-039 Back-to-back draws in IDLE: 5 consecutive valid cycles produce 5 mem_we pulses with matching addresses and data, zero bubbles.
